ms6205_responder: RTL and testbench
===================================

Name: ms6205_responder

Overview:
Display-side responder for the MS6205 character-display write protocol driven from the 8-bit emulator output bus. It captures address and data bytes on the write_addr/write_data strobes, stores characters in a DEPTH-entry frame buffer, and tracks the marker position. It paces the initiator through the ready handshake. It sits at the far end of the emulData bus, either as an on-FPGA display model or as the front end of a video/LCD renderer.

Parameters:
DEPTH, 160, number of character cells (10 rows x 16 columns); valid addresses are 0..DEPTH-1.
BUSY_CYCLES, 4, Clk cycles ready stays low after each accepted data write (minimum 1).
ADDR_WIDTH, 8, width of the address byte and read port.

Ports:
Clk  input  1  system clock.
Rst_n  input  1  asynchronous active-low reset.
bus_data  input  8  shared emulator output bus; sampled on strobe edges.
write_addr  input  1  address strobe, active-high level, asynchronous to Clk.
write_data  input  1  data strobe, active-high level, asynchronous to Clk.
marker  input  1  marker-enable level.
ready  output  1  high = responder accepts the next data strobe.
rd_addr  input  ADDR_WIDTH  frame-buffer read address (renderer side).
rd_data  output  8  registered frame-buffer read data.
marker_pos  output  ADDR_WIDTH  cell index under the marker.
marker_valid  output  1  marker currently displayed.
addr_err  output  1  sticky: an out-of-range address was received.
overrun_err  output  1  sticky: a strobe arrived while busy, or both strobes arrived together.

Behaviour:
- Reset (async, Rst_n=0) values: ready=1, rd_data=0, marker_pos=0, marker_valid=0, addr_err=0, overrun_err=0, addr_reg=0, FSM=IDLE. Frame buffer contents are not reset.
- write_addr, write_data and marker each pass through a 2-FF synchronizer. The strobes then go through a third flop for rising-edge detection.
- A strobe edge is detected 3 Clk edges after the input rises. Strobe pulses must be at least 2 Clk periods wide.
- FSM states: IDLE, BUSY, plus CLEAR when the optional feature is compiled in.
- IDLE, address edge only:
  - addr_reg <= bus_data (sampled through the same sync delay via a data register captured at the sync stage).
  - If bus_data >= DEPTH: addr_err <= 1, addr_reg is unchanged, and an internal addr_bad flag is set. The flag blocks data writes until the next valid address.
- IDLE, data edge only:
  - If addr_bad=0: mem[addr_reg] <= bus_data. addr_reg increments, wrapping from DEPTH-1 to 0. ready <= 0 in the same cycle and the FSM goes to BUSY.
  - If addr_bad=1: the byte is discarded and ready stays 1.
- Both edges in the same cycle: the address is processed as above, the data byte is discarded, and overrun_err <= 1.
- BUSY:
  - Counts BUSY_CYCLES cycles, then ready <= 1 and the FSM returns to IDLE.
  - Any strobe edge during BUSY is ignored and sets overrun_err.
- Marker:
  - marker_valid follows the synchronized marker level.
  - On the synchronized marker rising edge, marker_pos <= addr_reg.
  - While marker is high, marker_pos tracks addr_reg every cycle.
- Read port: rd_data <= mem[rd_addr] each cycle, 1-cycle latency. rd_addr >= DEPTH returns 0. A same-cycle write to the read address returns the old data.
- Sticky errors clear only on reset.
- Reset mid-BUSY or mid-CLEAR: the FSM returns to IDLE and ready=1 immediately. Cells already written keep their values.

Optional Feature:
MS6205_RESPONDER_CLEAR_EN:
- Defined: an address byte of 8'hFF is a clear command, not an error. ready <= 0 and the FSM enters CLEAR. It writes 8'h20 to cells 0..DEPTH-1, one per cycle, over DEPTH cycles. It then sets addr_reg=0, addr_bad=0, ready=1 and returns to IDLE. Strobes during CLEAR set overrun_err and are ignored.
- Undefined: the CLEAR state is absent and 8'hFF is an ordinary out-of-range address that sets addr_err.

Test Plan:
- Address strobe with bus 8'h05, then data strobe with 8'h41 -> ready falls 3 cycles after data rise and stays low 4 cycles; rd_addr=5 gives rd_data=8'h41 one cycle later; addr_reg=6.
- Address 159, then data 8'h31 and 8'h32 in two handshakes -> mem[159]=8'h31, mem[0]=8'h32 (wrap); no error flags.
- Address 8'hA0 (160), then a data strobe -> addr_err=1; mem unchanged; ready stays 1; a later address 3 then data write succeeds.
- Data strobe issued while ready=0 -> overrun_err=1; byte not written; the next handshaken write lands at the expected incremented address.
- Address 12, marker raised, then two data writes -> marker_valid=1; marker_pos reads 12, then 13, then 14. Marker lowered -> marker_valid=0 and marker_pos holds 14.
- CLEAR_EN build: address 8'hFF -> ready low for 160 cycles; all cells read 8'h20; addr_err=0. Rst_n pulsed mid-clear -> ready=1 at once and FSM=IDLE.

Source files
------------

// File: rtl/ms6205_responder_if.sv
// MS6205 emulator-output bus: shared data byte, address/data strobes, marker level and ready.
// The initiator drives the master side and the display responder sits on the slave side.
interface ms6205_responder_if;
    logic [7:0] bus_data;
    logic       write_addr;
    logic       write_data;
    logic       marker;
    logic       ready;

    modport master (
        output bus_data,
        output write_addr,
        output write_data,
        output marker,
        input  ready
    );

    modport slave (
        input  bus_data,
        input  write_addr,
        input  write_data,
        input  marker,
        output ready
    );
endinterface

// File: rtl/ms6205_responder.sv
// MS6205 display-side responder: synchronizes the write strobes, keeps the character frame buffer and marker.
// Define MS6205_RESPONDER_CLEAR_EN to turn address byte 8'hFF into a clear-screen command.
module ms6205_responder #(
    parameter int DEPTH       = 160,
    parameter int BUSY_CYCLES = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    ms6205_responder_if.slave     bus,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic [ADDR_WIDTH-1:0] marker_pos,
    output logic                  marker_valid,
    output logic                  addr_err,
    output logic                  overrun_err
);
    localparam int                    CNT_W     = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef MS6205_RESPONDER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

    state_t                state_q;
    logic                  ready_q;
    logic                  addr_bad_q;
    logic                  addr_err_q;
    logic                  overrun_err_q;
    logic                  marker_valid_q;
    logic [ADDR_WIDTH-1:0] addr_reg_q;
    logic [ADDR_WIDTH-1:0] marker_pos_q;
    logic [ADDR_WIDTH-1:0] addr_inc_d;
    logic [CNT_W-1:0]      busy_cnt_q;
`ifdef MS6205_RESPONDER_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_idx_q;
`endif
    logic [2:0]            wa_sync_q;
    logic [2:0]            wd_sync_q;
    logic [1:0]            mk_sync_q;
    logic [7:0]            bus_s1_q;
    logic [7:0]            bus_s2_q;
    logic [7:0]            rd_data_q;
    logic [7:0]            mem [DEPTH];

    logic                  addr_edge;
    logic                  data_edge;
    logic                  addr_oob;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_wdata;

    // Strobe/marker synchronizers; the strobes get a third flop for rising-edge detection.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wa_sync_q <= '0;
            wd_sync_q <= '0;
            mk_sync_q <= '0;
        end else begin
            wa_sync_q <= {wa_sync_q[1:0], bus.write_addr};
            wd_sync_q <= {wd_sync_q[1:0], bus.write_data};
            mk_sync_q <= {mk_sync_q[0], bus.marker};
        end
    end

    // The bus byte follows the same two-stage delay so it lines up with the detected edge.
    always_ff @(posedge Clk) begin
        bus_s1_q <= bus.bus_data;
        bus_s2_q <= bus_s1_q;
    end

    assign addr_edge  = wa_sync_q[1] & ~wa_sync_q[2];
    assign data_edge  = wd_sync_q[1] & ~wd_sync_q[2];
    assign addr_oob   = ({24'd0, bus_s2_q} >= 32'(DEPTH));
    assign addr_inc_d = (addr_reg_q == LAST_ADDR) ? '0 : addr_reg_q + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= IDLE;
            ready_q        <= 1'b1;
            addr_reg_q     <= '0;
            addr_bad_q     <= 1'b0;
            addr_err_q     <= 1'b0;
            overrun_err_q  <= 1'b0;
            busy_cnt_q     <= '0;
            marker_pos_q   <= '0;
            marker_valid_q <= 1'b0;
`ifdef MS6205_RESPONDER_CLEAR_EN
            clr_idx_q      <= '0;
`endif
        end else begin
            marker_valid_q <= mk_sync_q[1];
            // Covers both the capture on the marker rising edge and tracking while it stays high.
            if (mk_sync_q[1]) marker_pos_q <= addr_reg_q;

            case (state_q)
                IDLE: begin
                    if (addr_edge) begin
                        if (data_edge) overrun_err_q <= 1'b1;
`ifdef MS6205_RESPONDER_CLEAR_EN
                        if (bus_s2_q == 8'hFF) begin
                            ready_q   <= 1'b0;
                            clr_idx_q <= '0;
                            state_q   <= CLEAR;
                        end else
`endif
                        if (addr_oob) begin
                            addr_err_q <= 1'b1;
                            addr_bad_q <= 1'b1;
                        end else begin
                            addr_reg_q <= ADDR_WIDTH'(bus_s2_q);
                            addr_bad_q <= 1'b0;
                        end
                    end else if (data_edge && !addr_bad_q) begin
                        addr_reg_q <= addr_inc_d;
                        ready_q    <= 1'b0;
                        busy_cnt_q <= CNT_W'(BUSY_CYCLES - 1);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (addr_edge || data_edge) overrun_err_q <= 1'b1;
                    if (busy_cnt_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        busy_cnt_q <= busy_cnt_q - 1'b1;
                    end
                end
`ifdef MS6205_RESPONDER_CLEAR_EN
                CLEAR: begin
                    if (addr_edge || data_edge) overrun_err_q <= 1'b1;
                    if (clr_idx_q == LAST_ADDR) begin
                        addr_reg_q <= '0;
                        addr_bad_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_reg_q;
        mem_wdata = bus_s2_q;
        if (state_q == IDLE && data_edge && !addr_edge && !addr_bad_q) mem_we = 1'b1;
`ifdef MS6205_RESPONDER_CLEAR_EN
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = 8'h20;
        end
`endif
    end

    // Frame buffer holds its contents through reset.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rd_data_q <= '0;
        else        rd_data_q <= ({24'd0, rd_addr} < 32'(DEPTH)) ? mem[rd_addr] : 8'h00;
    end

    assign bus.ready    = ready_q;
    assign rd_data      = rd_data_q;
    assign marker_pos   = marker_pos_q;
    assign marker_valid = marker_valid_q;
    assign addr_err     = addr_err_q;
    assign overrun_err  = overrun_err_q;
endmodule

// File: tb/tb_ms6205_responder.sv
// Bench for ms6205_responder: directed handshakes plus randomized traffic against a cell-array model.
module tb_ms6205_responder;
    localparam int DEPTH       = 160;
    localparam int BUSY_CYCLES = 4;
    localparam int ADDR_WIDTH  = 8;

    logic                  clk     = 1'b0;
    logic                  rst_n   = 1'b0;
    logic [ADDR_WIDTH-1:0] rd_addr = '0;
    logic [7:0]            rd_data;
    logic [ADDR_WIDTH-1:0] marker_pos;
    logic                  marker_valid;
    logic                  addr_err;
    logic                  overrun_err;

    ms6205_responder_if bus_if ();

    ms6205_responder #(
        .DEPTH      (DEPTH),
        .BUSY_CYCLES(BUSY_CYCLES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .bus         (bus_if),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .marker_pos  (marker_pos),
        .marker_valid(marker_valid),
        .addr_err    (addr_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    byte unsigned mdl_mem [DEPTH];
    bit           known   [DEPTH];
    int           mdl_addr;
    bit           mdl_bad;
    bit           mdl_aerr;
    bit           mdl_oerr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a plain array of cells, a cursor and the error flags.
    function automatic void mdl_reset();
        mdl_addr = 0;
        mdl_bad  = 1'b0;
        mdl_aerr = 1'b0;
        mdl_oerr = 1'b0;
    endfunction

    function automatic void mdl_address(input int b);
        if (b >= DEPTH) begin
            mdl_aerr = 1'b1;
            mdl_bad  = 1'b1;
        end else begin
            mdl_addr = b;
            mdl_bad  = 1'b0;
        end
    endfunction

    function automatic void mdl_write(input int b);
        if (!mdl_bad) begin
            mdl_mem[mdl_addr] = 8'(b);
            known[mdl_addr]   = 1'b1;
            mdl_addr          = (mdl_addr + 1) % DEPTH;
        end
    endfunction

    // All driving tasks start and end on a falling clock edge.
    task automatic pulse(input bit is_data, input int b, input int hold, input int low);
        bus_if.bus_data = 8'(b);
        if (is_data) bus_if.write_data = 1'b1;
        else         bus_if.write_addr = 1'b1;
        repeat (hold) @(negedge clk);
        bus_if.write_addr = 1'b0;
        bus_if.write_data = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus_if.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.ready !== 1'b1) check_val("ready_timeout", 32'(bus_if.ready), 32'd1);
    endtask

    task automatic do_addr(input int b);
        pulse(1'b0, b, 2, 2);
        mdl_address(b);
    endtask

    task automatic do_write(input int b, input string tag);
        wait_ready();
        pulse(1'b1, b, 2, 2);
        check_val({tag, "_ready"}, 32'(bus_if.ready), mdl_bad ? 32'd1 : 32'd0);
        mdl_write(b);
        wait_ready();
    endtask

    task automatic rd_check(input int a, input string tag);
        rd_addr = ADDR_WIDTH'(a);
        @(negedge clk);
        if (a >= DEPTH)    check_val(tag, 32'(rd_data), 32'd0);
        else if (known[a]) check_val(tag, 32'(rd_data), 32'(mdl_mem[a]));
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, "_addr_err"}, 32'(addr_err), 32'(mdl_aerr));
        check_val({tag, "_overrun"}, 32'(overrun_err), 32'(mdl_oerr));
    endtask

    // The marker position exposes the internal cell cursor.
    task automatic check_addr_reg(input string tag);
        bus_if.marker = 1'b1;
        repeat (4) @(negedge clk);
        check_val({tag, "_mpos"}, 32'(marker_pos), 32'(mdl_addr));
        bus_if.marker = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op;
        int b;
        bus_if.bus_data   = '0;
        bus_if.write_addr = 1'b0;
        bus_if.write_data = 1'b0;
        bus_if.marker     = 1'b0;
        mdl_reset();
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(bus_if.ready), 32'd1);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        check_val("rst_mpos", 32'(marker_pos), 32'd0);
        check_val("rst_mvalid", 32'(marker_valid), 32'd0);
        check_flags("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write with handshake timing.
        do_addr(8'h05);
        wait_ready();
        bus_if.bus_data   = 8'h41;
        bus_if.write_data = 1'b1;
        n = 0;
        while (bus_if.ready === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("t1_fall_latency", 32'(n), 32'd3);
        bus_if.write_data = 1'b0;
        n = 0;
        while (bus_if.ready === 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("t1_busy_len", 32'(n), 32'(BUSY_CYCLES));
        mdl_write(8'h41);
        rd_check(5, "t1_rd");
        check_addr_reg("t1");

        // Wrap from the last cell back to cell 0.
        do_addr(159);
        do_write(8'h31, "t2a");
        do_write(8'h32, "t2b");
        rd_check(159, "t2_rd159");
        rd_check(0, "t2_rd0");
        check_flags("t2");

        // Out-of-range address blocks data until a valid address.
        do_addr(8'hA0);
        do_write(8'h99, "t3_blocked");
        check_flags("t3");
        rd_check(159, "t3_rd159");
        rd_check(0, "t3_rd0");
        do_addr(3);
        do_write(8'h5A, "t3_ok");
        rd_check(3, "t3_rd3");

        // Data strobe while busy is an overrun.
        do_addr(20);
        wait_ready();
        pulse(1'b1, 8'h55, 2, 1);
        pulse(1'b1, 8'h66, 2, 2);
        mdl_write(8'h55);
        mdl_oerr = 1'b1;
        wait_ready();
        check_flags("t4");
        do_write(8'h77, "t4_next");
        rd_check(20, "t4_rd20");
        rd_check(21, "t4_rd21");

        // Reset keeps the frame buffer, then both strobes together.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        @(negedge clk);
        check_flags("t5_rst");
        rd_check(20, "t5_keep20");
        do_addr(7);
        do_write(8'h11, "t5_pre");
        bus_if.bus_data   = 8'd7;
        bus_if.write_addr = 1'b1;
        bus_if.write_data = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.write_addr = 1'b0;
        bus_if.write_data = 1'b0;
        repeat (2) @(negedge clk);
        mdl_address(7);
        mdl_oerr = 1'b1;
        check_val("t5_both_ready", 32'(bus_if.ready), 32'd1);
        check_flags("t5_both");
        rd_check(7, "t5_rd7");
        check_addr_reg("t5");

        // Marker tracking.
        do_addr(12);
        bus_if.marker = 1'b1;
        repeat (4) @(negedge clk);
        check_val("t6_mvalid", 32'(marker_valid), 32'd1);
        check_val("t6_mpos0", 32'(marker_pos), 32'(mdl_addr));
        do_write(8'h61, "t6a");
        repeat (2) @(negedge clk);
        check_val("t6_mpos1", 32'(marker_pos), 32'(mdl_addr));
        do_write(8'h62, "t6b");
        repeat (2) @(negedge clk);
        check_val("t6_mpos2", 32'(marker_pos), 32'(mdl_addr));
        bus_if.marker = 1'b0;
        repeat (4) @(negedge clk);
        check_val("t6_mvalid_off", 32'(marker_valid), 32'd0);
        check_val("t6_mpos_hold", 32'(marker_pos), 32'd14);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                if ($urandom_range(0, 3) == 0) b = int'($urandom_range(160, 254));
                else                           b = int'($urandom_range(0, 159));
                do_addr(b);
            end else if (op == 9 && !mdl_bad) begin
                wait_ready();
                b = int'($urandom_range(0, 255));
                pulse(1'b1, b, 2, 1);
                pulse(1'b1, int'($urandom_range(0, 255)), 2, 2);
                mdl_write(b);
                mdl_oerr = 1'b1;
                wait_ready();
            end else begin
                do_write(int'($urandom_range(0, 255)), "rnd_wr");
            end
            rd_check(int'($urandom_range(0, 175)), "rnd_rd");
            check_flags("rnd");
        end
        check_addr_reg("rnd_end");

`ifdef MS6205_RESPONDER_CLEAR_EN
        // Clear command fills every cell with spaces.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        @(negedge clk);
        bus_if.bus_data   = 8'hFF;
        bus_if.write_addr = 1'b1;
        n = 0;
        while (bus_if.ready === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bus_if.write_addr = 1'b0;
        n = 0;
        while (bus_if.ready === 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("clr_len", 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = 8'h20;
            known[i]   = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) rd_check(i, "clr_cell");
        check_flags("clr");
        check_addr_reg("clr");

        bus_if.bus_data   = 8'hFF;
        bus_if.write_addr = 1'b1;
        n = 0;
        while (bus_if.ready === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bus_if.write_addr = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("clr_rst_ready", 32'(bus_if.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        @(negedge clk);
        do_addr(2);
        do_write(8'h44, "clr_after");
        rd_check(2, "clr_after_rd");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
